// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED pattern sequencer.
//   - state_t      : sequencer FSM states
//   - OFS_*        : control slave word offsets
//   - CTRL_*       : CTRL register bit positions (write and read views)
//   - DEFAULT_DATA_W : LED pattern width matching the 14-bit LED PIO
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 14;

  localparam logic [3:0] OFS_CTRL       = 4'd0;
  localparam logic [3:0] OFS_LEN        = 4'd1;
  localparam logic [3:0] OFS_DWELL      = 4'd2;
  localparam logic [3:0] OFS_INDEX      = 4'd3;
  localparam logic [3:0] OFS_TABLE_BASE = 4'd8;

  // CTRL write view
  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_CLEAR  = 3;
  localparam int CTRL_IRQ_EN = 4;
  // CTRL read view (loop and irq_en share their write positions)
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_DONE   = 2;

endpackage

// File: rtl/led_seq_regs.sv
// led_seq_regs: control slave decode, stored configuration and pattern table.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   ctl_*                  : Avalon-MM control slave (combinational read data)
//   busy, done, index      : sequencer status, reflected in CTRL / INDEX reads
//   tbl_addr / tbl_data    : asynchronous table read port used by the sequencer
//   start/stop/clear_pulse : single-cycle command strobes decoded from CTRL writes
//   loop_en, irq_en        : stored CTRL fields
//   len_eff                : LEN clamped to DEPTH
//   dwell                  : stored dwell cycle count
module led_seq_regs
  import led_seq_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         ctl_address,
  input  logic               ctl_chipselect,
  input  logic               ctl_write_n,
  input  logic [31:0]        ctl_writedata,
  output logic [31:0]        ctl_readdata,
  input  logic               busy,
  input  logic               done,
  input  logic [3:0]         index,
  input  logic [2:0]         tbl_addr,
  output logic [DATA_W-1:0]  tbl_data,
  output logic               start_pulse,
  output logic               stop_pulse,
  output logic               clear_pulse,
  output logic               loop_en,
  output logic               irq_en,
  output logic [3:0]         len_eff,
  output logic [DWELL_W-1:0] dwell
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(DEPTH);

  logic [DATA_W-1:0] tbl [DEPTH];
  logic [3:0]        len;
  logic              wr;
  logic              ctrl_wr;
  logic              tbl_hit;
  logic              unused_wdata;

  // Only some write-data bits land in registers; the rest are don't-care.
  assign unused_wdata = ^ctl_writedata;

  assign wr      = ctl_chipselect && !ctl_write_n;
  assign ctrl_wr = wr && (ctl_address == OFS_CTRL);
  assign tbl_hit = ctl_address[3] && ({1'b0, ctl_address[2:0]} < DEPTH4);

  assign start_pulse = ctrl_wr && ctl_writedata[CTRL_START];
  assign stop_pulse  = ctrl_wr && ctl_writedata[CTRL_STOP];
  assign clear_pulse = ctrl_wr && ctl_writedata[CTRL_CLEAR];

  // LEN reads back as written; only the sequencer sees the clamped value.
  assign len_eff  = (len > DEPTH4) ? DEPTH4 : len;
  assign tbl_data = tbl[tbl_addr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_en <= 1'b0;
      irq_en  <= 1'b0;
      len     <= '0;
      dwell   <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr) begin
      if (ctrl_wr) begin
        loop_en <= ctl_writedata[CTRL_LOOP];
        irq_en  <= ctl_writedata[CTRL_IRQ_EN];
      end
      if (ctl_address == OFS_LEN)   len   <= ctl_writedata[3:0];
      if (ctl_address == OFS_DWELL) dwell <= ctl_writedata[DWELL_W-1:0];
      if (tbl_hit) tbl[ctl_address[IDX_W-1:0]] <= ctl_writedata[DATA_W-1:0];
    end
  end

  always_comb begin
    ctl_readdata = '0;
    if (ctl_chipselect) begin
      case (ctl_address)
        OFS_CTRL: begin
          ctl_readdata[CTRL_BUSY]   = busy;
          ctl_readdata[CTRL_LOOP]   = loop_en;
          ctl_readdata[CTRL_DONE]   = done;
          ctl_readdata[CTRL_IRQ_EN] = irq_en;
        end
        OFS_LEN:   ctl_readdata[3:0]         = len;
        OFS_DWELL: ctl_readdata[DWELL_W-1:0] = dwell;
        OFS_INDEX: ctl_readdata[3:0]         = index;
        default: begin
          if (tbl_hit) ctl_readdata[DATA_W-1:0] = tbl[ctl_address[IDX_W-1:0]];
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps the LED PIO through a software-loaded pattern
// table, holding each entry for a programmable dwell, once or looped.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   ctl_*            : Avalon-MM control slave (CTRL/LEN/DWELL/INDEX/TABLE)
//   m_*              : Avalon-MM master to the PIO s1 slave (registered outputs)
//   busy             : sequencer not idle (registered)
//   irq              : level interrupt, done & irq_en
//
// Handshake: a PIO write is presented with m_chipselect=1, m_write_n=0 and
// completes on the first clock edge where m_waitrequest=0; address and data
// stay stable for the whole time chipselect is held.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ctl_address,
  input  logic        ctl_chipselect,
  input  logic        ctl_write_n,
  input  logic [31:0] ctl_writedata,
  output logic [31:0] ctl_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        irq
);

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t              state, state_next;
  logic [3:0]          index, index_next;
  logic [DWELL_W-1:0]  cnt, cnt_next;
  logic [DWELL_W-1:0]  dwell_load;
  logic                stop_pend, stop_pend_next;
  logic                done, done_set;

  logic                start_pulse, stop_pulse, clear_pulse;
  logic                loop_en, irq_en;
  logic [3:0]          len_eff;
  logic [DWELL_W-1:0]  dwell;
  logic [DATA_W-1:0]   tbl_data;

  led_seq_regs #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .DWELL_W (DWELL_W)
  ) u_regs (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctl_address    (ctl_address),
    .ctl_chipselect (ctl_chipselect),
    .ctl_write_n    (ctl_write_n),
    .ctl_writedata  (ctl_writedata),
    .ctl_readdata   (ctl_readdata),
    .busy           (busy),
    .done           (done),
    .index          (index),
    .tbl_addr       (index_next[2:0]),
    .tbl_data       (tbl_data),
    .start_pulse    (start_pulse),
    .stop_pulse     (stop_pulse),
    .clear_pulse    (clear_pulse),
    .loop_en        (loop_en),
    .irq_en         (irq_en),
    .len_eff        (len_eff),
    .dwell          (dwell)
  );

  // A zero dwell still holds the pattern for one cycle.
  assign dwell_load = (dwell == '0) ? CNT_ONE : dwell;

  assign m_address = 2'b00;
  assign irq       = done && irq_en;

  always_comb begin
    state_next     = state;
    index_next     = index;
    cnt_next       = cnt;
    stop_pend_next = stop_pend;
    done_set       = 1'b0;
    case (state)
      ST_IDLE: begin
        stop_pend_next = 1'b0;
        // stop in the same write as start wins
        if (start_pulse && !stop_pulse) begin
          if (len_eff != 4'd0) begin
            index_next = 4'd0;
            state_next = ST_WRITE;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // A stop cannot abort a presented transfer; remember it until accepted.
        if (stop_pulse) stop_pend_next = 1'b1;
        if (!m_waitrequest) begin
          if (stop_pend || stop_pulse) begin
            state_next     = ST_IDLE;
            stop_pend_next = 1'b0;
          end else begin
            state_next = ST_DWELL;
            cnt_next   = dwell_load;
          end
        end
      end
      ST_DWELL: begin
        if (stop_pulse) begin
          state_next = ST_IDLE;
        end else if (cnt <= CNT_ONE) begin
          // LEN may have shrunk mid-run, so test index+1 rather than index==LEN-1.
          if (({1'b0, index} + 5'd1) < {1'b0, len_eff}) begin
            index_next = index + 4'd1;
            state_next = ST_WRITE;
          end else if (loop_en) begin
            index_next = 4'd0;
            state_next = ST_WRITE;
          end else begin
            done_set   = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Master outputs and busy are registered from the next state so they line
  // up with the state register without a combinational path to the fabric.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      index        <= 4'd0;
      cnt          <= '0;
      stop_pend    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      state        <= state_next;
      index        <= index_next;
      cnt          <= cnt_next;
      stop_pend    <= stop_pend_next;
      // a done event beats a simultaneous clear
      done         <= done_set || (done && !clear_pulse);
      busy         <= (state_next != ST_IDLE);
      m_chipselect <= (state_next == ST_WRITE);
      m_write_n    <= (state_next != ST_WRITE);
      // Latch data only on entry to WRITE so it holds through a stall even if
      // software rewrites the table meanwhile.
      if (state_next == ST_WRITE && state != ST_WRITE) begin
        m_writedata <= 32'(tbl_data);
      end
    end
  end

endmodule
